// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port, with a wait watchdog.
// Define ARB_ROUND_ROBIN_EN for alternating priority on collisions; otherwise data always wins.
module mem_arbiter #(
    parameter int N   = 64,
    parameter int W   = 32,
    parameter int TMO = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ireq,
    input  logic [W-1:0] iaddr,
    output logic [31:0]  irdata,
    output logic         ivalid,
    output logic         iabort,
    input  logic         dreq,
    input  logic         dwe,
    input  logic [W-1:0] daddr,
    input  logic [N-1:0] dwdata,
    output logic [N-1:0] drdata,
    output logic         dvalid,
    output logic         mreq,
    output logic         mwe,
    output logic [W-1:0] maddr,
    output logic [N-1:0] mwdata,
    input  logic [N-1:0] mrdata,
    input  logic         mready,
    output logic         tmo_err
);

    typedef enum logic [2:0] {IDLE, IGNT, IWAIT, DGNT, DWAIT} state_t;

    localparam logic [7:0] TMO_L = 8'(TMO);

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_wdog;
    logic [7:0]     w_wdog_inc;
    logic           r_ivalid, r_dvalid, r_iabort, r_tmo_err, r_mwe;
    logic [31:0]    r_irdata;
    logic [N-1:0]   r_drdata, r_mwdata;
    logic [W-1:0]   r_maddr;
    logic           w_any_req, w_pick_d, w_wait, w_idone, w_ddone, w_tmo, w_grant, w_mreq;

    assign w_any_req  = ireq | dreq;
    assign w_grant    = (r_state == IDLE) && w_any_req;
    assign w_wait     = (r_state == IWAIT) || (r_state == DWAIT);
    assign w_idone    = (r_state == IWAIT) && mready;
    assign w_ddone    = (r_state == DWAIT) && mready;
    assign w_wdog_inc = r_wdog + 8'd1;
    // completion wins over a timeout landing on the same cycle
    assign w_tmo      = w_wait && !mready && (w_wdog_inc == TMO_L);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;  // 1: data side won the previous grant

    assign w_pick_d = dreq && !(ireq && r_last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_last_d <= 1'b1;
        else if (w_grant) r_last_d <= w_pick_d;
    end
`else
    assign w_pick_d = dreq;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mreq      = 1'b0;
        case (r_state)
            IDLE:  if (w_any_req) w_state_nxt = w_pick_d ? DGNT : IGNT;
            IGNT:  begin
                w_mreq      = 1'b1;
                w_state_nxt = IWAIT;
            end
            DGNT:  begin
                w_mreq      = 1'b1;
                w_state_nxt = DWAIT;
            end
            IWAIT, DWAIT: if (mready || w_tmo) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog    <= '0;
            r_ivalid  <= 1'b0;
            r_dvalid  <= 1'b0;
            r_iabort  <= 1'b0;
            r_tmo_err <= 1'b0;
            r_irdata  <= '0;
            r_drdata  <= '0;
            r_maddr   <= '0;
            r_mwe     <= 1'b0;
            r_mwdata  <= '0;
        end else begin
            r_ivalid <= w_idone;
            r_dvalid <= w_ddone;
            if (w_idone)            r_irdata <= mrdata[31:0];
            if (w_ddone && !r_mwe)  r_drdata <= mrdata;
            if (w_grant) begin
                r_maddr  <= w_pick_d ? daddr : iaddr;
                r_mwe    <= w_pick_d & dwe;
                r_mwdata <= w_pick_d ? dwdata : '0;
            end
            if ((r_state == IGNT) || (r_state == DGNT)) r_wdog <= '0;
            else if (w_wait && !mready)                 r_wdog <= w_wdog_inc;
            if (w_tmo) r_tmo_err <= 1'b1;
            // pending fetch survives timeouts and dropped requests; only its completion clears it
            if (w_idone)   r_iabort <= 1'b0;
            else if (ireq) r_iabort <= 1'b1;
        end
    end

    assign mreq    = w_mreq;
    assign mwe     = r_mwe;
    assign maddr   = r_maddr;
    assign mwdata  = r_mwdata;
    assign irdata  = r_irdata;
    assign ivalid  = r_ivalid;
    assign iabort  = r_iabort;
    assign drdata  = r_drdata;
    assign dvalid  = r_dvalid;
    assign tmo_err = r_tmo_err;

endmodule
